// File: rtl/uram_read_scheduler_if.sv
// Bus bundle for uram_read_scheduler: stream read requests, write
// requester, URAM read/write ports and the tagged response stream.
// slave  = the scheduler, master = requesters / URAM / consumer side.
interface uram_read_scheduler_if #(
  parameter int N_STREAMS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = $clog2(N_STREAMS)
);
  // stream read requesters
  logic [N_STREAMS-1:0]            i_rd_req;
  logic [N_STREAMS*ADDR_WIDTH-1:0] i_rd_addr;
  logic [N_STREAMS-1:0]            o_rd_gnt;
  // write requester
  logic                            i_wr_valid;
  logic [ADDR_WIDTH-1:0]           i_wr_addr;
  logic [DATA_WIDTH-1:0]           i_wr_data;
  // URAM ports
  logic                            o_uram_we;
  logic [ADDR_WIDTH-1:0]           o_uram_wa;
  logic [DATA_WIDTH-1:0]           o_uram_wd;
  logic                            o_uram_re;
  logic [ADDR_WIDTH-1:0]           o_uram_ra;
  logic [DATA_WIDTH-1:0]           i_uram_rd;
  // response stream
  logic                            o_rsp_valid;
  logic [ID_WIDTH-1:0]             o_rsp_id;
  logic [DATA_WIDTH-1:0]           o_rsp_data;
  logic                            i_rsp_ready;

  modport slave (
    input  i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
           i_uram_rd, i_rsp_ready,
    output o_rd_gnt, o_uram_we, o_uram_wa, o_uram_wd, o_uram_re,
           o_uram_ra, o_rsp_valid, o_rsp_id, o_rsp_data
  );

  modport master (
    output i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data,
           i_uram_rd, i_rsp_ready,
    input  o_rd_gnt, o_uram_we, o_uram_wa, o_uram_wd, o_uram_re,
           o_uram_ra, o_rsp_valid, o_rsp_id, o_rsp_data
  );
endinterface

// File: rtl/uram_read_scheduler.sv
// Round-robin scheduler sharing one URAM read port between N stream
// requesters. Reads are tagged with the stream ID, carried through a
// valid/ID shift register matching the RAM latency, and landed in a
// first-word-fall-through response FIFO. A registered credit counter
// (FIFO entries + reads in flight) gates grants so the consumer can
// stall without any returning read being dropped. The write requester
// goes straight to the URAM write port through one register stage.
module uram_read_scheduler #(
  parameter int N_STREAMS   = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 12,
  parameter int RAM_LATENCY = 2,
  parameter int RSP_DEPTH   = 4,
  parameter int ID_WIDTH    = $clog2(N_STREAMS)
) (
  input  logic                 clk2x,
  input  logic                 reset,
  uram_read_scheduler_if.slave bus
);
  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  // tag pipeline tail index: stage 0 travels with o_uram_re, stage
  // RAM_LATENCY lines up with valid read data on i_uram_rd
  localparam int STAGES = RAM_LATENCY;

  // ---------------- arbitration / credit ----------------
  logic [N_STREAMS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic                                 found;
  logic [ID_WIDTH-1:0]                  cand;
  logic [ID_WIDTH-1:0]                  gnt_id;
  logic                                 issue;
  logic [N_STREAMS-1:0]                 rd_gnt;
  logic [ID_WIDTH-1:0]                  last_q, last_d;
  logic [OCC_W-1:0]                     occ_q, occ_d;

  // ---------------- URAM port registers ----------------
  logic                  we_q, re_q;
  logic [ADDR_WIDTH-1:0] wa_q, ra_q;
  logic [DATA_WIDTH-1:0] wd_q;

  // ---------------- tag pipeline ----------------
  logic [STAGES:0]               vld_pipe_q;
  logic [STAGES:0][ID_WIDTH-1:0] id_pipe_q;

  // ---------------- response FIFO ----------------
  logic [RSP_DEPTH-1:0][ID_WIDTH-1:0]   fifo_id_q;
  logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data_q;
  logic [PTR_W-1:0]                     wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]                     cnt_q, cnt_d;
  logic                                 push, pop, rsp_valid;

  // per-stream address bus viewed as one word per stream
  assign rd_addr = bus.i_rd_addr;

  // round-robin search starting one past the last granted stream
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int i = 1; i <= N_STREAMS; i++) begin
      cand = ID_WIDTH'((int'(last_q) + i) % N_STREAMS);
      if (!found && bus.i_rd_req[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
  end

  // grant only with a free credit; reset forces the grant low
  always_comb begin
    issue          = found && !reset && (occ_q < OCC_W'(RSP_DEPTH));
    rd_gnt         = '0;
    rd_gnt[gnt_id] = issue;
    last_d         = issue ? gnt_id : last_q;
  end

  assign bus.o_rd_gnt = rd_gnt;

  // credit tracks granted-but-not-popped reads; push into the FIFO
  // only moves a read from in-flight to stored, so it is not counted
  always_comb begin
    occ_d = occ_q + OCC_W'(issue) - OCC_W'(pop);
  end

  // pointer and credit registers
  always_ff @(posedge clk2x) begin
    if (reset) begin
      last_q <= ID_WIDTH'(N_STREAMS - 1);
      occ_q  <= '0;
    end else begin
      last_q <= last_d;
      occ_q  <= occ_d;
    end
  end

  // write port: one register stage, no arbitration
  always_ff @(posedge clk2x) begin
    if (reset) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= bus.i_wr_valid;
      wa_q <= bus.i_wr_addr;
      wd_q <= bus.i_wr_data;
    end
  end

  // read port issue plus valid/ID tag shift register; clearing the
  // tags on reset discards data from reads issued before reset
  always_ff @(posedge clk2x) begin
    if (reset) begin
      re_q       <= 1'b0;
      ra_q       <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      re_q       <= issue;
      ra_q       <= issue ? rd_addr[gnt_id] : ra_q;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], issue};
      id_pipe_q  <= {id_pipe_q[STAGES-1:0], gnt_id};
    end
  end

  assign bus.o_uram_we = we_q;
  assign bus.o_uram_wa = wa_q;
  assign bus.o_uram_wd = wd_q;
  assign bus.o_uram_re = re_q;
  assign bus.o_uram_ra = ra_q;

  // FIFO control; the credit guarantees a push never finds it full
  assign push      = vld_pipe_q[STAGES];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && bus.i_rsp_ready;

  always_comb begin
    cnt_d = cnt_q + OCC_W'(push) - OCC_W'(pop);
  end

  // FIFO pointers and fill count
  always_ff @(posedge clk2x) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage: tail tag paired with the returning URAM word
  always_ff @(posedge clk2x) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]   <= id_pipe_q[STAGES];
      fifo_data_q[wr_ptr_q] <= bus.i_uram_rd;
    end
  end

  // head of FIFO falls through; zeroed while empty so outputs are
  // clean after reset
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q]   : '0;
  assign bus.o_rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;

endmodule
